// File: rtl/resize_pkg.sv
// Shared types and constants for the resize stage controller.
package resize_pkg;

   localparam int PIX_W = 8;
   localparam int DIM_W = 8;

   localparam logic [DIM_W-1:0] RESIZE_DEF_WIDTH  = 8'd64;
   localparam logic [DIM_W-1:0] RESIZE_DEF_HEIGHT = 8'd64;
   localparam int               RESIZE_FRAME_GAP  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FRAME  = 3'd1,
      ACTIVE = 3'd2,
      LINE   = 3'd3,
      FGAP   = 3'd4
   } resizeStateT;

endpackage

// File: rtl/resize_ctrl_shadow.sv
// Pending/active Width/Height registers; a write with either dimension zero is dropped,
// and the active pair only changes when the controller enters FRAME.
module resize_ctrl_shadow
   import resize_pkg::*;
#(
   parameter logic [DIM_W-1:0] DEF_WIDTH  = RESIZE_DEF_WIDTH,
   parameter logic [DIM_W-1:0] DEF_HEIGHT = RESIZE_DEF_HEIGHT
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CfgWrite,
   input  logic [DIM_W-1:0] CfgWidth,
   input  logic [DIM_W-1:0] CfgHeight,
   input  logic             loadActive,
   output logic [DIM_W-1:0] Width,
   output logic [DIM_W-1:0] Height
);

   logic [DIM_W-1:0] pendWidth;
   logic [DIM_W-1:0] pendHeight;
   logic             cfgAccept;

   assign cfgAccept = CfgWrite && (CfgWidth != '0) && (CfgHeight != '0);

   // Active loads the old pending value, so a write on the load edge lands in the next frame.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pendWidth  <= DEF_WIDTH;
         pendHeight <= DEF_HEIGHT;
         Width      <= DEF_WIDTH;
         Height     <= DEF_HEIGHT;
      end else begin
         if (cfgAccept) begin
            pendWidth  <= CfgWidth;
            pendHeight <= CfgHeight;
         end
         if (loadActive) begin
            Width  <= pendWidth;
            Height <= pendHeight;
         end
      end
   end

endmodule

// File: rtl/resize_ctrl.sv
// Frame sequencer for the resize stage: paces upstream pixels into a no-stall Pixel/Frame/Line stream.
// Optional RESIZE_CTRL_STATS_EN adds saturating FrameCount/UnderrunCount outputs.
module resize_ctrl
   import resize_pkg::*;
#(
   parameter logic [DIM_W-1:0] DEF_WIDTH  = RESIZE_DEF_WIDTH,
   parameter logic [DIM_W-1:0] DEF_HEIGHT = RESIZE_DEF_HEIGHT,
   parameter int               FRAME_GAP  = RESIZE_FRAME_GAP
)
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic             CfgWrite,
   input  logic [DIM_W-1:0] CfgWidth,
   input  logic [DIM_W-1:0] CfgHeight,
   input  logic [PIX_W-1:0] SrcPixel,
   input  logic             SrcValid,
   output logic             SrcReady,
   output logic [PIX_W-1:0] PixelOut,
   output logic             FrameOut,
   output logic             LineOut,
   output logic [DIM_W-1:0] Width,
   output logic [DIM_W-1:0] Height,
   output logic             Busy,
   output logic             FrameDone,
   output logic             Underrun
`ifdef RESIZE_CTRL_STATS_EN
   ,
   output logic [15:0]      FrameCount,
   output logic [15:0]      UnderrunCount
`endif
);

   localparam logic [7:0] GAP_LAST = 8'(FRAME_GAP - 1);

   resizeStateT      state;
   resizeStateT      nextState;
   logic [DIM_W-1:0] col;
   logic [DIM_W-1:0] row;
   logic [7:0]       gapCnt;
   logic             stopReq;
   logic             lastCol;
   logic             lastRow;
   logic             startAccept;
   logic             loadActive;

   assign lastCol     = (col == Width - 8'd1);
   assign lastRow     = (row == Height - 8'd1);
   assign startAccept = (state == IDLE) && Start && !Stop;
   assign loadActive  = (nextState == FRAME);
   assign SrcReady    = (state == ACTIVE);
   assign Busy        = (state != IDLE);

   resize_ctrl_shadow #(
      .DEF_WIDTH  (DEF_WIDTH),
      .DEF_HEIGHT (DEF_HEIGHT)
   ) shadow (
      .Clk        (Clk),
      .Reset      (Reset),
      .CfgWrite   (CfgWrite),
      .CfgWidth   (CfgWidth),
      .CfgHeight  (CfgHeight),
      .loadActive (loadActive),
      .Width      (Width),
      .Height     (Height)
   );

   // A Stop seen on the last gap cycle counts as well as one latched earlier.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (startAccept) nextState = FRAME;
         FRAME:   nextState = ACTIVE;
         ACTIVE:  if (lastCol) nextState = lastRow ? FGAP : LINE;
         LINE:    nextState = ACTIVE;
         FGAP:    if (gapCnt == GAP_LAST) nextState = (stopReq || Stop) ? IDLE : FRAME;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         gapCnt  <= '0;
         stopReq <= 1'b0;
      end else begin
         state  <= nextState;
         gapCnt <= '0;
         case (state)
            FRAME: begin
               col <= '0;
               row <= '0;
            end
            ACTIVE: col <= col + 8'd1;
            LINE: begin
               col <= '0;
               row <= row + 8'd1;
            end
            FGAP:    gapCnt <= gapCnt + 8'd1;
            default: ;
         endcase
         if (nextState == IDLE)
            stopReq <= 1'b0;
         else if (state != IDLE && Stop)
            stopReq <= 1'b1;
      end
   end

   // Output stage: one register behind the state that produced it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         PixelOut  <= '0;
         FrameOut  <= 1'b0;
         LineOut   <= 1'b0;
         FrameDone <= 1'b0;
         Underrun  <= 1'b0;
      end else begin
         PixelOut  <= (state == ACTIVE && SrcValid) ? SrcPixel : '0;
         FrameOut  <= (state == FRAME);
         LineOut   <= (state == LINE);
         FrameDone <= (state == ACTIVE) && lastCol && lastRow;
         if (startAccept)
            Underrun <= 1'b0;
         else if (state == ACTIVE && !SrcValid)
            Underrun <= 1'b1;
      end
   end

`ifdef RESIZE_CTRL_STATS_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         FrameCount    <= '0;
         UnderrunCount <= '0;
      end else begin
         if (FrameDone && FrameCount != 16'hFFFF)
            FrameCount <= FrameCount + 16'd1;
         if (state == ACTIVE && !SrcValid && UnderrunCount != 16'hFFFF)
            UnderrunCount <= UnderrunCount + 16'd1;
      end
   end
`endif

endmodule
